uart_dpram_buffer: RTL and testbench
====================================

# uart_dpram_buffer

Parametrised byte buffer between a UART receiver and a UART transmitter. Received words go into a circular dual-port RAM. A one-cycle dump request, normally from the debounced key, replays the stored words in arrival order through a send/done handshake with the transmitter. Compared with the first-generation UART-to-RAM design, it adds configurable word width and depth, full/empty/count status, a selectable keep-or-clear dump mode and overflow handling.

## Interface
- DATA_W, default 8: word width (UART payload).
- ADDR_W, default 8: RAM address width; depth = 2**ADDR_W.
- CLEAR_ON_DUMP, default 1: 1 frees each word once it is sent; 0 leaves contents intact so the buffer can be replayed.
- Clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- rx_data  in  DATA_W  received word; valid when rx_done = 1.
- rx_done  in  1  one-cycle strobe from the receiver.
- dump_req  in  1  one-cycle dump request.
- tx_data  out  DATA_W  word presented to the transmitter.
- send_en  out  1  one-cycle transmit start strobe.
- tx_done  in  1  one-cycle strobe from the transmitter: word sent.
- busy  out  1  dump in progress.
- count  out  ADDR_W+1  words stored.
- full  out  1  count == 2**ADDR_W.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a write arrived while full.

## Operation
- Reset values: tx_data=0, send_en=0, busy=0, count=0, full=0, empty=1, overflow=0, wr_ptr=rd_ptr=0, state IDLE.
- Write port: on rx_done with not full, store mem[wr_ptr]=rx_data, then wr_ptr+1 (mod depth) and count+1. Full behaviour is set under Configuration.
- Pointers are ADDR_W bits and wrap from depth-1 to 0.
- Dump FSM states:
  - IDLE: on dump_req with count != 0, snapshot rem=count and dp=rd_ptr, then go to RD. dump_req with count == 0 is ignored and busy never rises.
  - RD: drive RAM read address dp, then go to LOAD.
  - LOAD: register q into tx_data, pulse send_en, then go to WAIT.
  - WAIT: on tx_done, dp+1 and rem-1. If CLEAR_ON_DUMP, also rd_ptr+1 and count-1. Go to RD if rem was more than 1, otherwise IDLE.
- dump_req while busy is ignored.
- Writes during a dump are accepted but are not part of the current dump (snapshot semantics).
- Simultaneous write and clear-mode free in the same cycle: count is unchanged.
- Starting a dump clears overflow.
- CLEAR_ON_DUMP=0: rd_ptr and count are never changed by a dump.
- tx_done outside WAIT is ignored.
- Rst during a dump: immediate return to IDLE, send_en=0, contents discarded (count=0).

## Timing
- rx_done sampled at edge N: count/full/empty updated after edge N+1.
- dump_req sampled at edge T: busy=1 after T+1; send_en high for exactly the cycle after edge T+2, with tx_data already valid.
- tx_data is held stable from send_en until the next LOAD.
- tx_done sampled at edge D, more words remaining: next send_en high in the cycle after edge D+2.
- tx_done sampled at edge D, last word: busy=0 after edge D+1.
- RAM is simple dual port with a registered read, one-cycle latency.

## Configuration
- UART_BUF_OVERWRITE_EN defined: a write while full overwrites the oldest word. mem[wr_ptr]=rx_data, wr_ptr+1 and rd_ptr+1; count stays at depth; overflow=1. While busy, the full write is dropped instead, to protect the snapshot.
- UART_BUF_OVERWRITE_EN undefined: a write while full is dropped; overflow=1; pointers and count are unchanged.

## Structure
- Package uart_buf_pkg holds:
  - FSM state encodings (IDLE, RD, LOAD, WAIT);
  - default DATA_W/ADDR_W constants.
- Sub-module uart_buf_ram: simple dual-port RAM, DATA_W x 2**ADDR_W, one write port, one registered read port.

## Test plan
- Write AA,55,33,AF, then dump_req (CLEAR_ON_DUMP=1): four send_en pulses carrying AA,55,33,AF in order; count goes 4 to 0; empty=1; busy=0 one cycle after the 4th tx_done.
- Same sequence with CLEAR_ON_DUMP=0, dumped twice: AA,55,33,AF sent both times; count stays 4.
- ADDR_W=2, write 5 words 01..05:
  - without macro: count=4, full=1, overflow=1, dump sends 01..04;
  - with macro: dump sends 02..05.
- dump_req while empty: busy, send_en and count all stay 0.
- rx_done 0x77 arriving during a 2-word dump: only the 2 words are sent; count ends at 1 in clear mode; a second dump sends 77.
- Rst asserted between send_en and tx_done: next cycle busy=0, count=0, empty=1, and a late tx_done has no effect.

Source files
------------

// File: rtl/uart_buf_pkg.sv
// uart_buf_pkg: shared constants and dump FSM encoding for uart_dpram_buffer.
// Optional feature macro: UART_BUF_OVERWRITE_EN (used in uart_dpram_buffer).
package uart_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LOAD = 2'd2,
        WAIT = 2'd3
    } dump_state_e;

endpackage

// File: rtl/uart_buf_if.sv
// uart_buf_if: receiver/transmitter handshake and status bundle.
// The master side is the surrounding UART logic; the slave side is the buffer.
interface uart_buf_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();

    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              dump_req;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;
    logic              send_en;
    logic              busy;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output rx_data, rx_done, dump_req, tx_done,
        input  tx_data, send_en, busy, count, full, empty, overflow
    );

    modport slave (
        input  rx_data, rx_done, dump_req, tx_done,
        output tx_data, send_en, busy, count, full, empty, overflow
    );

endinterface

// File: rtl/uart_buf_ram.sv
// uart_buf_ram: simple dual-port RAM, one write port and one registered
// read port with single-cycle latency. A read of an address being written in
// the same cycle returns the old contents.
module uart_buf_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port.
    // NOTE: the array has no reset so it maps onto block RAM; occupancy is
    // tracked by the pointers and count in the buffer, not by the contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_dpram_buffer.sv
// uart_dpram_buffer: circular byte buffer between a UART receiver and
// transmitter. Received words are written to a dual-port RAM; a dump request
// replays a snapshot of the stored words through a send/done handshake.
// Optional feature macro: UART_BUF_OVERWRITE_EN -- a write while full replaces
// the oldest word (when no dump is running) instead of being dropped.
module uart_dpram_buffer
    import uart_buf_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int CLEAR_ON_DUMP = 1
) (
    input logic       clk,
    input logic       rst,
    uart_buf_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    // Registered receiver word: writes commit one edge after rx_done is seen.
    logic              rx_vld_q,  rx_vld_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;

    // Circular buffer bookkeeping.
    logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              overflow_q, overflow_d;

    // Dump engine: snapshot pointer and words remaining.
    dump_state_e       state_q,   state_d;
    logic [ADDR_W-1:0] dp_q,      dp_d;
    logic [ADDR_W:0]   rem_q,     rem_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              send_en_q, send_en_d;
    logic              busy_q,    busy_d;

    // RAM ports and per-cycle events.
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              is_full;
    logic              dump_start;
    logic              word_added;
    logic              word_freed;

    assign is_full = (count_q == FULL_CNT);

    uart_buf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (rx_word_q),
        .re    (ram_re),
        .raddr (dp_q),
        .rdata (ram_rdata)
    );

    // Next-state logic: dump FSM, write path, pointer and count updates.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        rx_vld_d   = bus.rx_done;
        rx_word_d  = bus.rx_data;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        dp_d       = dp_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;
        send_en_d  = 1'b0;
        busy_d     = (state_q != IDLE);
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        dump_start = 1'b0;
        word_added = 1'b0;
        word_freed = 1'b0;

        case (state_q)
            IDLE: begin
                // An empty buffer never starts a dump.
                if (bus.dump_req && (count_q != '0)) begin
                    dump_start = 1'b1;
                    rem_d      = count_q;
                    dp_d       = rd_ptr_q;
                    state_d    = RD;
                end
            end
            RD: begin
                ram_re  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                tx_data_d = ram_rdata;
                send_en_d = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    dp_d       = dp_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    word_freed = (CLEAR_ON_DUMP != 0);
                    state_d    = (rem_q > REM_ONE) ? RD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dump_start) begin
            overflow_d = 1'b0;
        end

        // Write path; words arriving during a dump land outside the snapshot.
        if (rx_vld_q) begin
            if (!is_full) begin
                ram_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                word_added = 1'b1;
            end else begin
                overflow_d = 1'b1;
`ifdef UART_BUF_OVERWRITE_EN
                // Replace the oldest word, but never under a running (or
                // just-starting) dump whose snapshot includes that word.
                if ((state_q == IDLE) && !dump_start) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
`endif
            end
        end

        if (word_freed) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A write and a free in the same cycle leave the count unchanged.
        case ({word_added, word_freed})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; reset discards stored words.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_vld_q   <= 1'b0;
            rx_word_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            dp_q       <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            send_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_vld_q   <= rx_vld_d;
            rx_word_q  <= rx_word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            dp_q       <= dp_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            send_en_q  <= send_en_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.send_en  = send_en_q;
    assign bus.busy     = busy_q;
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.empty    = (count_q == '0);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_dpram_buffer.sv
// tb_uart_dpram_buffer: three buffer instances (clear mode, keep mode, and a
// 4-deep clear-mode buffer) driven from per-instance stimulus arrays.
module tb_uart_dpram_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus, index 0 = clear/256-deep, 1 = keep/256-deep, 2 = clear/4-deep.
    logic       rst_s      [3];
    logic [7:0] rx_data_s  [3];
    logic       rx_done_s  [3];
    logic       dump_req_s [3];
    logic       tx_done_s  [3];

    wire  [7:0] tx_data_o  [3];
    wire  [8:0] count_o    [3];
    wire  [2:0] send_en_o;
    wire  [2:0] busy_o;
    wire  [2:0] full_o;
    wire  [2:0] empty_o;
    wire  [2:0] overflow_o;

    uart_buf_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
    uart_buf_if #(.DATA_W(8), .ADDR_W(8)) ifb ();
    uart_buf_if #(.DATA_W(8), .ADDR_W(2)) ifc ();

    uart_dpram_buffer #(.DATA_W(8), .ADDR_W(8), .CLEAR_ON_DUMP(1)) dut_a (
        .clk (clk), .rst (rst_s[0]), .bus (ifa));
    uart_dpram_buffer #(.DATA_W(8), .ADDR_W(8), .CLEAR_ON_DUMP(0)) dut_b (
        .clk (clk), .rst (rst_s[1]), .bus (ifb));
    uart_dpram_buffer #(.DATA_W(8), .ADDR_W(2), .CLEAR_ON_DUMP(1)) dut_c (
        .clk (clk), .rst (rst_s[2]), .bus (ifc));

    assign ifa.rx_data = rx_data_s[0];  assign ifa.rx_done = rx_done_s[0];
    assign ifa.dump_req = dump_req_s[0]; assign ifa.tx_done = tx_done_s[0];
    assign ifb.rx_data = rx_data_s[1];  assign ifb.rx_done = rx_done_s[1];
    assign ifb.dump_req = dump_req_s[1]; assign ifb.tx_done = tx_done_s[1];
    assign ifc.rx_data = rx_data_s[2];  assign ifc.rx_done = rx_done_s[2];
    assign ifc.dump_req = dump_req_s[2]; assign ifc.tx_done = tx_done_s[2];

    assign tx_data_o[0] = ifa.tx_data;  assign tx_data_o[1] = ifb.tx_data;
    assign tx_data_o[2] = ifc.tx_data;
    assign count_o[0] = ifa.count;      assign count_o[1] = ifb.count;
    assign count_o[2] = {6'd0, ifc.count};
    assign send_en_o  = {ifc.send_en,  ifb.send_en,  ifa.send_en};
    assign busy_o     = {ifc.busy,     ifb.busy,     ifa.busy};
    assign full_o     = {ifc.full,     ifb.full,     ifa.full};
    assign empty_o    = {ifc.empty,    ifb.empty,    ifa.empty};
    assign overflow_o = {ifc.overflow, ifb.overflow, ifa.overflow};

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       dump_req;
        logic       tx_done;
        logic       exp_send;
        logic       chk_tx;
        logic [7:0] exp_tx;
        logic       exp_busy;
        logic [8:0] exp_count;
    } vec_t;

    localparam int N_VEC = 20;
    vec_t       vecs  [N_VEC];
    logic [7:0] exp_w [8];

    function automatic vec_t mk(input logic rxd, input logic [7:0] rxw,
                                input logic dq, input logic td,
                                input logic se, input logic ct,
                                input logic [7:0] tx, input logic b,
                                input logic [8:0] c);
        vec_t v;
        v.rx_done = rxd; v.rx_data = rxw; v.dump_req = dq; v.tx_done = td;
        v.exp_send = se; v.chk_tx = ct; v.exp_tx = tx; v.exp_busy = b;
        v.exp_count = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int sel, input logic [7:0] d);
        rx_data_s[sel] = d;
        rx_done_s[sel] = 1'b1;
        step();
        rx_done_s[sel] = 1'b0;
    endtask

    // Pulse dump_req, then expect n send_en pulses carrying exp_w[0..n-1],
    // answering each with tx_done. With inject set, 0x77 arrives on the
    // receiver together with the first tx_done.
    task automatic run_dump(input int sel, input int n, input bit inject,
                            input string tag);
        int waited;
        dump_req_s[sel] = 1'b1;
        step();
        dump_req_s[sel] = 1'b0;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!send_en_o[sel] && waited < 20) begin
                step();
                waited++;
            end
            check($sformatf("%s_send%0d", tag, k), {31'd0, send_en_o[sel]}, 32'd1);
            if (!send_en_o[sel]) return;
            check($sformatf("%s_data%0d", tag, k), {24'd0, tx_data_o[sel]},
                  {24'd0, exp_w[k]});
            tx_done_s[sel] = 1'b1;
            if (inject && k == 0) begin
                rx_data_s[sel] = 8'h77;
                rx_done_s[sel] = 1'b1;
            end
            step();
            tx_done_s[sel] = 1'b0;
            rx_done_s[sel] = 1'b0;
        end
        step();
        check({tag, "_busy_end"}, {31'd0, busy_o[sel]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; rx_data_s[i] = 8'h00; rx_done_s[i] = 1'b0;
            dump_req_s[i] = 1'b0; tx_done_s[i] = 1'b0;
        end

        //          rxd rxw    dq td  se ct tx     b  cnt
        vecs[0]  = mk(1, 8'hAA, 0, 0, 0, 0, 8'h00, 0, 9'd0);
        vecs[1]  = mk(1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 9'd1);
        vecs[2]  = mk(1, 8'h33, 0, 0, 0, 0, 8'h00, 0, 9'd2);
        vecs[3]  = mk(1, 8'hAF, 0, 0, 0, 0, 8'h00, 0, 9'd3);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 9'd4);
        vecs[5]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 9'd4);
        vecs[6]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 9'd4); // tx_done in RD
        vecs[7]  = mk(0, 8'h00, 0, 0, 1, 1, 8'hAA, 1, 9'd4);
        vecs[8]  = mk(0, 8'h00, 1, 0, 0, 1, 8'hAA, 1, 9'd4); // dump_req busy
        vecs[9]  = mk(0, 8'h00, 0, 1, 0, 1, 8'hAA, 1, 9'd3);
        vecs[10] = mk(0, 8'h00, 0, 0, 0, 1, 8'hAA, 1, 9'd3);
        vecs[11] = mk(0, 8'h00, 0, 0, 1, 1, 8'h55, 1, 9'd3);
        vecs[12] = mk(0, 8'h00, 0, 1, 0, 1, 8'h55, 1, 9'd2);
        vecs[13] = mk(0, 8'h00, 0, 0, 0, 1, 8'h55, 1, 9'd2);
        vecs[14] = mk(0, 8'h00, 0, 0, 1, 1, 8'h33, 1, 9'd2);
        vecs[15] = mk(0, 8'h00, 0, 1, 0, 1, 8'h33, 1, 9'd1);
        vecs[16] = mk(0, 8'h00, 0, 0, 0, 1, 8'h33, 1, 9'd1);
        vecs[17] = mk(0, 8'h00, 0, 0, 1, 1, 8'hAF, 1, 9'd1);
        vecs[18] = mk(0, 8'h00, 0, 1, 0, 1, 8'hAF, 1, 9'd0);
        vecs[19] = mk(0, 8'h00, 0, 0, 0, 1, 8'hAF, 0, 9'd0);

        step();
        step();
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

        // Reset state of every instance.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_tx_data", i), {24'd0, tx_data_o[i]}, 32'd0);
            check($sformatf("rst%0d_send_en", i), {31'd0, send_en_o[i]}, 32'd0);
            check($sformatf("rst%0d_busy", i), {31'd0, busy_o[i]}, 32'd0);
            check($sformatf("rst%0d_count", i), {23'd0, count_o[i]}, 32'd0);
            check($sformatf("rst%0d_full", i), {31'd0, full_o[i]}, 32'd0);
            check($sformatf("rst%0d_empty", i), {31'd0, empty_o[i]}, 32'd1);
            check($sformatf("rst%0d_overflow", i), {31'd0, overflow_o[i]}, 32'd0);
        end

        // Cycle-accurate clear-mode dump of AA,55,33,AF.
        for (int i = 0; i < N_VEC; i++) begin
            rx_done_s[0]  = vecs[i].rx_done;
            rx_data_s[0]  = vecs[i].rx_data;
            dump_req_s[0] = vecs[i].dump_req;
            tx_done_s[0]  = vecs[i].tx_done;
            step();
            check($sformatf("vec%0d_send_en", i), {31'd0, send_en_o[0]},
                  {31'd0, vecs[i].exp_send});
            check($sformatf("vec%0d_busy", i), {31'd0, busy_o[0]},
                  {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_count", i), {23'd0, count_o[0]},
                  {23'd0, vecs[i].exp_count});
            check($sformatf("vec%0d_empty", i), {31'd0, empty_o[0]},
                  {31'd0, (vecs[i].exp_count == 9'd0)});
            if (vecs[i].chk_tx)
                check($sformatf("vec%0d_tx_data", i), {24'd0, tx_data_o[0]},
                      {24'd0, vecs[i].exp_tx});
        end
        rx_done_s[0] = 1'b0; dump_req_s[0] = 1'b0; tx_done_s[0] = 1'b0;

        // Keep mode: two identical replays, count unchanged.
        do_write(1, 8'hAA); do_write(1, 8'h55); do_write(1, 8'h33); do_write(1, 8'hAF);
        step();
        check("keep_count_pre", {23'd0, count_o[1]}, 32'd4);
        exp_w[0] = 8'hAA; exp_w[1] = 8'h55; exp_w[2] = 8'h33; exp_w[3] = 8'hAF;
        run_dump(1, 4, 1'b0, "keep1");
        check("keep_count_1", {23'd0, count_o[1]}, 32'd4);
        run_dump(1, 4, 1'b0, "keep2");
        check("keep_count_2", {23'd0, count_o[1]}, 32'd4);
        check("keep_empty", {31'd0, empty_o[1]}, 32'd0);

        // 4-deep buffer, five writes: full and overflow handling.
        for (int i = 1; i <= 5; i++) do_write(2, 8'(i));
        step();
        check("ovf_count", {23'd0, count_o[2]}, 32'd4);
        check("ovf_full", {31'd0, full_o[2]}, 32'd1);
        check("ovf_overflow", {31'd0, overflow_o[2]}, 32'd1);
`ifdef UART_BUF_OVERWRITE_EN
        exp_w[0] = 8'h02; exp_w[1] = 8'h03; exp_w[2] = 8'h04; exp_w[3] = 8'h05;
`else
        exp_w[0] = 8'h01; exp_w[1] = 8'h02; exp_w[2] = 8'h03; exp_w[3] = 8'h04;
`endif
        run_dump(2, 4, 1'b0, "ovf");
        check("ovf_count_end", {23'd0, count_o[2]}, 32'd0);
        check("ovf_cleared", {31'd0, overflow_o[2]}, 32'd0);
        check("ovf_empty_end", {31'd0, empty_o[2]}, 32'd1);

        // Dump request while empty is ignored.
        dump_req_s[2] = 1'b1;
        step();
        dump_req_s[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("empty_dump_busy%0d", i), {31'd0, busy_o[2]}, 32'd0);
            check($sformatf("empty_dump_send%0d", i), {31'd0, send_en_o[2]}, 32'd0);
        end
        check("empty_dump_count", {23'd0, count_o[2]}, 32'd0);

        // Snapshot: 0x77 arrives mid-dump and is not part of that dump.
        do_write(0, 8'h11); do_write(0, 8'h22);
        step();
        exp_w[0] = 8'h11; exp_w[1] = 8'h22;
        run_dump(0, 2, 1'b1, "snap");
        check("snap_count", {23'd0, count_o[0]}, 32'd1);
        exp_w[0] = 8'h77;
        run_dump(0, 1, 1'b0, "snap2");
        check("snap2_count", {23'd0, count_o[0]}, 32'd0);

        // Reset between send_en and tx_done.
        do_write(0, 8'h5A);
        step();
        dump_req_s[0] = 1'b1;
        step();
        dump_req_s[0] = 1'b0;
        step();
        step();
        check("rstd_send_en", {31'd0, send_en_o[0]}, 32'd1);
        rst_s[0] = 1'b1;
        step();
        rst_s[0] = 1'b0;
        check("rstd_busy", {31'd0, busy_o[0]}, 32'd0);
        check("rstd_count", {23'd0, count_o[0]}, 32'd0);
        check("rstd_empty", {31'd0, empty_o[0]}, 32'd1);
        check("rstd_send_off", {31'd0, send_en_o[0]}, 32'd0);
        tx_done_s[0] = 1'b1;
        step();
        tx_done_s[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("late_done_busy%0d", i), {31'd0, busy_o[0]}, 32'd0);
            check($sformatf("late_done_send%0d", i), {31'd0, send_en_o[0]}, 32'd0);
            check($sformatf("late_done_count%0d", i), {23'd0, count_o[0]}, 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
